// File: rtl/core_control_branch_redirect_pkg.sv
// Shared core control types: pointers, control cycles, decode bundles.
// Used by core_control_branch_redirect and its optional RAS (CORE_BRANCH_RAS_EN).
package core_control_branch_redirect_pkg;

    localparam int PTR_BITS_DEF     = 30;
    localparam int OFFSET_BITS_DEF  = 24;
    localparam int RESET_VECTOR_DEF = 0;

    typedef logic [PTR_BITS_DEF-1:0] ptr;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EXECUTE,
        WRITEBACK
    } ctrl_cycle;

    typedef struct packed {
        logic branch;
        logic load;
        logic store;
        logic alu;
    } datapath_decode;

    typedef struct packed {
        logic [OFFSET_BITS_DEF-1:0] offset;
        logic                       link;
        logic                       indirect;
        logic                       ret;
    } branch_decode;

endpackage

// File: rtl/core_control_branch_ras.sv
// Circular return-address stack with pop-then-push and registered miss.
// Instantiated only in CORE_BRANCH_RAS_EN builds.
module core_control_branch_ras
    import core_control_branch_redirect_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PTR_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_value,
    input  logic [WIDTH-1:0] compare_value,
    output logic             miss
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [IDX_W-1:0] wp;
    logic [CNT_W-1:0] cnt;

    logic             pop_ok;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] base_wp;
    logic [CNT_W-1:0] base_cnt;
    logic [IDX_W-1:0] next_wp;
    logic [CNT_W-1:0] next_cnt;

    // The pop is resolved first so a link-and-return reuses the popped slot.
    always_comb begin
        pop_ok   = pop && (cnt != '0);
        top_idx  = wp - IDX_W'(1);
        base_wp  = wp;
        base_cnt = cnt;
        if (pop_ok) begin
            base_wp  = top_idx;
            base_cnt = cnt - CNT_W'(1);
        end
        next_wp  = base_wp;
        next_cnt = base_cnt;
        if (push) begin
            next_wp  = base_wp + IDX_W'(1);
            next_cnt = (base_cnt == CNT_W'(DEPTH)) ? base_cnt : base_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            cnt  <= '0;
            miss <= 1'b0;
        end else begin
            miss <= pop_ok && (stack[top_idx] != compare_value);
            if (push) begin
                stack[base_wp] <= push_value;
            end
            wp  <= next_wp;
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/core_control_branch_redirect.sv
// Issue-stage redirect unit: one registered fetch redirect under valid/ready.
// Optional return-address stack checking enabled by CORE_BRANCH_RAS_EN.
module core_control_branch_redirect
    import core_control_branch_redirect_pkg::*;
#(
    parameter int                  PTR_BITS     = PTR_BITS_DEF,
    parameter int                  OFFSET_BITS  = OFFSET_BITS_DEF,
    parameter logic [PTR_BITS-1:0] RESET_VECTOR = PTR_BITS'(RESET_VECTOR_DEF),
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  ctrl_cycle           next_cycle,
    input  logic                issue,
    input  datapath_decode      dec,
    input  branch_decode        dec_branch,
    input  logic [PTR_BITS-1:0] next_pc_visible,
    input  logic [PTR_BITS-1:0] indirect_target,
    input  logic                vector_valid,
    input  logic [PTR_BITS-1:0] vector_target,
    input  logic                branch_ready,
    output logic                branch,
    output logic [PTR_BITS-1:0] branch_target,
    output logic                stall,
    output logic                ras_miss
);

    logic                          fire;
    logic signed [OFFSET_BITS-1:0] offset;
    logic [PTR_BITS-1:0]           direct_target;
    logic                          src_valid;
    logic [PTR_BITS-1:0]           src_target;
    logic                          unused_bits;

    assign fire          = (next_cycle == ISSUE) && issue;
    assign offset        = dec_branch.offset[OFFSET_BITS-1:0];
    assign direct_target = next_pc_visible + PTR_BITS'(offset);
    assign stall         = branch && !branch_ready;
    assign unused_bits   = ^{dec, dec_branch};

    always_comb begin
        src_valid  = 1'b1;
        src_target = direct_target;
        if (vector_valid) begin
            src_target = vector_target;
        end else if (fire && dec_branch.indirect) begin
            src_target = indirect_target;
        end else if (!(fire && dec.branch)) begin
            src_valid = 1'b0;
        end
    end

    // A new source always replaces whatever is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch        <= 1'b1;
            branch_target <= RESET_VECTOR;
        end else if (src_valid) begin
            branch        <= 1'b1;
            branch_target <= src_target;
        end else if (branch && branch_ready) begin
            branch <= 1'b0;
        end
    end

`ifdef CORE_BRANCH_RAS_EN
    logic ras_op;

    assign ras_op = fire && !vector_valid;

    core_control_branch_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (PTR_BITS)
    ) u_ras (
        .clk           (clk),
        .rst           (rst),
        .push          (ras_op && dec_branch.link),
        .pop           (ras_op && dec_branch.ret),
        .push_value    (next_pc_visible - 1'b1),
        .compare_value (indirect_target),
        .miss          (ras_miss)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;

    assign ras_miss = 1'b0;
`endif

endmodule
